// File: rtl/jt12_wr_master_pkg.sv
// jt12_wr_master_pkg
//   Shared types and constants for the JT12 write-port initiator.
//   wr_state_e : sequencer states (address phase, settle, wait; data phase, settle, wait)
//   PH_ADDR / PH_DATA : low bit of the jt12 addr bus selecting address or data write
//   wr_req_t   : one queued register write {bank, register number, value}
package jt12_wr_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_ASETL = 3'd2,
    ST_AWAIT = 3'd3,
    ST_DATA  = 3'd4,
    ST_DSETL = 3'd5,
    ST_DWAIT = 3'd6
  } wr_state_e;

  localparam logic PH_ADDR = 1'b0;
  localparam logic PH_DATA = 1'b1;

  typedef struct packed {
    logic       bank;
    logic [7:0] rnum;
    logic [7:0] val;
  } wr_req_t;

  localparam int REQ_W = $bits(wr_req_t);

  // Key used by the address cache: which bank/register the chip has selected.
  function automatic logic [8:0] sel_key(input wr_req_t r);
    return {r.bank, r.rnum};
  endfunction

endpackage

// File: rtl/jt12_wr_fifo.sv
// jt12_wr_fifo
//   Request queue, depth 1<<AW, first-word-fall-through read (dout is the head entry).
//   clk, rst_n     : clock, async active-low reset
//   push, din      : enqueue; ignored when full or during flush
//   pop            : dequeue head; ignored when empty or during flush
//   flush          : synchronous clear, wins over push/pop
//   dout           : head entry (valid when !empty)
//   full, empty    : occupancy flags
module jt12_wr_fifo #(
  parameter int AW = 2,
  parameter int W  = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  // A full queue refuses a push even if the head leaves in the same cycle.
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign dout    = mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/jt12_wr_master.sv
// jt12_wr_master
//   Drains queued register writes onto the JT12 CPU port: address write, then data write,
//   waiting for busy to drop after each strobe. The address phase is skipped when the
//   cached bank/register already matches (ADDR_CACHE=1).
//   clk, rst_n          : clock (jt12_mmr domain), async active-low reset
//   req_valid/req_ready : request handshake (ready = queue not full)
//   req_bank/reg/val    : request payload
//   flush               : abort everything, empty queue, drop cache
//   write, addr, din    : registered jt12 write port (addr = {bank, phase})
//   busy                : jt12_mmr busy
//   idle                : queue empty and sequencer idle
//   err_timeout         : sticky, a phase waited WAIT_MAX busy cycles
//
//   state | meaning
//   IDLE  | waiting for a queued request and busy low; pops into hold regs
//   ADDR  | address strobe out (write=1, addr={bank,0}, din=reg)
//   ASETL | dead cycle while mmr raises busy
//   AWAIT | wait for busy low after address write
//   DATA  | data strobe out (write=1, addr={bank,1}, din=val)
//   DSETL | dead cycle while mmr raises busy
//   DWAIT | wait for busy low after data write
import jt12_wr_master_pkg::*;

module jt12_wr_master #(
  parameter int AW         = 2,
  parameter int ADDR_CACHE = 1,
  parameter int WAIT_MAX   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_bank,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_val,
  input  logic       flush,
  output logic       write,
  output logic [1:0] addr,
  output logic [7:0] din,
  input  logic       busy,
  output logic       idle,
  output logic       err_timeout
);
  localparam logic [7:0] WAIT_LD = 8'(WAIT_MAX);

  wr_state_e        state_q, state_d;
  wr_req_t          head, hold_q, src;
  logic [REQ_W-1:0] fifo_dout;
  logic             fifo_full, fifo_empty;
  logic             push, pop, tmo, hit;
  logic [8:0]       cache_key_q;
  logic             cache_vld_q;
  logic [7:0]       wait_cnt_q;

  assign push      = req_valid & ~fifo_full & ~flush;
  assign req_ready = ~fifo_full;
  assign head      = wr_req_t'(fifo_dout);
  // In IDLE the strobe payload comes straight from the entry being popped.
  assign src       = (state_q == ST_IDLE) ? head : hold_q;
  assign hit       = (ADDR_CACHE != 0) && cache_vld_q && (sel_key(head) == cache_key_q);
  assign idle      = fifo_empty && (state_q == ST_IDLE);

  jt12_wr_fifo #(
    .AW (AW),
    .W  (REQ_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({req_bank, req_reg, req_val}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !busy) begin
          pop     = 1'b1;
          state_d = hit ? ST_DATA : ST_ADDR;
        end
      end
      ST_ADDR:  state_d = ST_ASETL;
      ST_ASETL: state_d = ST_AWAIT;
      ST_AWAIT: begin
        if (!busy) begin
          state_d = ST_DATA;
        end else if (wait_cnt_q == 8'd1) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DATA:  state_d = ST_DSETL;
      ST_DSETL: state_d = ST_DWAIT;
      ST_DWAIT: begin
        if (!busy) begin
          state_d = ST_IDLE;
        end else if (wait_cnt_q == 8'd1) begin
          tmo     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      pop     = 1'b0;
      tmo     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      wait_cnt_q  <= '0;
      write       <= 1'b0;
      addr        <= '0;
      din         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q <= state_d;
      if (pop) hold_q <= head;

      if (flush || tmo) begin
        cache_vld_q <= 1'b0;
      end else if (state_q == ST_ADDR) begin
        cache_key_q <= sel_key(hold_q);
        cache_vld_q <= 1'b1;
      end

      // Down-counter of busy cycles still allowed; reloaded in the settle cycle so
      // each wait phase gets exactly WAIT_MAX busy cycles before timing out.
      if (state_q == ST_ASETL || state_q == ST_DSETL) begin
        wait_cnt_q <= WAIT_LD;
      end else if ((state_q == ST_AWAIT || state_q == ST_DWAIT) && busy) begin
        wait_cnt_q <= wait_cnt_q - 1'b1;
      end

      if (tmo) err_timeout <= 1'b1;

      // Strobes are registered off the next state, so write lines up with ADDR/DATA.
      write <= 1'b0;
      if (state_d == ST_ADDR) begin
        write <= 1'b1;
        addr  <= {src.bank, PH_ADDR};
        din   <= src.rnum;
      end else if (state_d == ST_DATA) begin
        write <= 1'b1;
        addr  <= {src.bank, PH_DATA};
        din   <= src.val;
      end
    end
  end

endmodule

// File: tb/tb_jt12_wr_master.sv
module tb_jt12_wr_master;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_bank;
  logic [7:0] req_reg;
  logic [7:0] req_val;
  logic       flush;
  logic       write;
  logic [1:0] addr;
  logic [7:0] din;
  logic       busy;
  logic       idle;
  logic       err_timeout;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  int bus_len = 0;
  bit force_busy = 1'b0;
  int bcnt = 0;

  logic [9:0] log_q[$];
  int         log_cyc[$];
  int         b2b_cnt = 0;
  logic       prev_wr = 1'b0;

  jt12_wr_master #(
    .AW         (2),
    .ADDR_CACHE (1),
    .WAIT_MAX   (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_bank    (req_bank),
    .req_reg     (req_reg),
    .req_val     (req_val),
    .flush       (flush),
    .write       (write),
    .addr        (addr),
    .din         (din),
    .busy        (busy),
    .idle        (idle),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // jt12_mmr-like busy: rises the cycle after a strobe and stays for bus_len cycles.
  always @(posedge clk) begin
    if (write) bcnt <= bus_len;
    else if (bcnt > 0) bcnt <= bcnt - 1;
  end
  assign busy = force_busy || (bcnt != 0);

  always @(negedge clk) begin
    if (write) begin
      log_q.push_back({addr, din});
      log_cyc.push_back(cyc);
    end
    if (write && prev_wr) b2b_cnt++;
    prev_wr = write;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [9:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 10'h3FF;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < log_cyc.size()) return log_cyc[i];
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    log_q.delete();
    log_cyc.delete();
  endtask

  task automatic drive_req(input logic b, input logic [7:0] r, input logic [7:0] v,
                           output logic acc);
    req_valid = 1'b1;
    req_bank  = b;
    req_reg   = r;
    req_val   = v;
    acc       = req_ready;
    tick(1);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int k;
    k = 0;
    tick(1);
    while (!idle && k < max) begin
      tick(1);
      k++;
    end
    chk_val({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n0;
    logic acc;
    logic [4:0] accv;

    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_bank  = 1'b0;
    req_reg   = '0;
    req_val   = '0;
    flush     = 1'b0;
    tick(3);
    chk_val("rst_write", write, 0);
    chk_val("rst_addr", addr, 0);
    chk_val("rst_din", din, 0);
    chk_val("rst_err", err_timeout, 0);
    chk_val("rst_idle", idle, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    chk_val("rst_ready", req_ready, 1);

    // 1: single write, busy low -> strobes at N+2 and N+5, idle at N+8
    clear_log();
    bus_len = 0;
    n0 = cyc;
    drive_req(1'b0, 8'h28, 8'hF0, acc);
    chk_val("t1_acc", acc, 1);
    tick(6);
    chk_val("t1_idle_n7", idle, 0);
    tick(1);
    chk_val("t1_idle_n8", idle, 1);
    chk_val("t1_nstrobe", log_q.size(), 2);
    chk_val("t1_addr_strobe", log_at(0), {2'd0, 8'h28});
    chk_val("t1_data_strobe", log_at(1), {2'd1, 8'hF0});
    chk_val("t1_addr_lat", cyc_at(0) - n0, 2);
    chk_val("t1_data_lat", cyc_at(1) - n0, 5);

    // 2: same bank/reg twice -> one address strobe, two data strobes
    clear_log();
    bus_len = 3;
    drive_req(1'b1, 8'hA4, 8'h22, acc);
    drive_req(1'b1, 8'hA4, 8'h23, acc);
    wait_idle("t2", 200);
    chk_val("t2_nstrobe", log_q.size(), 3);
    chk_val("t2_s0", log_at(0), {2'd2, 8'hA4});
    chk_val("t2_s1", log_at(1), {2'd3, 8'h22});
    chk_val("t2_s2", log_at(2), {2'd3, 8'h23});

    // 3: five pushes with busy held high -> four accepted, issued in order
    clear_log();
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_req(1'b0, 8'h30 + 8'(i), 8'(i + 1), acc);
      accv[i] = acc;
    end
    chk_val("t3_accepts", accv, 5'b01111);
    chk_val("t3_ready_full", req_ready, 0);
    chk_val("t3_no_strobe", log_q.size(), 0);
    force_busy = 1'b0;
    wait_idle("t3", 400);
    chk_val("t3_nstrobe", log_q.size(), 8);
    for (int i = 0; i < 4; i++) begin
      chk_val($sformatf("t3_addr%0d", i), log_at(2 * i), {2'd0, 8'h30 + 8'(i)});
      chk_val($sformatf("t3_data%0d", i), log_at(2 * i + 1), {2'd1, 8'(i + 1)});
    end

    // 4: busy stuck after address strobe -> timeout after 16 wait cycles
    clear_log();
    bus_len = 0;
    drive_req(1'b0, 8'h40, 8'h55, acc);
    tick(1);
    force_busy = 1'b1;
    tick(17);
    chk_val("t4_err_early", err_timeout, 0);
    tick(1);
    chk_val("t4_err_set", err_timeout, 1);
    chk_val("t4_idle", idle, 1);
    chk_val("t4_nstrobe", log_q.size(), 1);
    chk_val("t4_addr_only", log_at(0), {2'd0, 8'h40});
    force_busy = 1'b0;
    clear_log();
    drive_req(1'b0, 8'h40, 8'h66, acc);
    wait_idle("t4_retry", 200);
    chk_val("t4_retry_n", log_q.size(), 2);
    chk_val("t4_retry_addr", log_at(0), {2'd0, 8'h40});
    chk_val("t4_retry_data", log_at(1), {2'd1, 8'h66});

    // 5: flush in DWAIT with three queued -> nothing more issued, cache dropped
    clear_log();
    drive_req(1'b0, 8'h50, 8'h01, acc);
    drive_req(1'b0, 8'h51, 8'h02, acc);
    drive_req(1'b0, 8'h52, 8'h03, acc);
    drive_req(1'b0, 8'h53, 8'h04, acc);
    tick(2);
    force_busy = 1'b1;
    tick(2);
    chk_val("t5_pre_flush_n", log_q.size(), 2);
    flush = 1'b1;
    tick(1);
    flush = 1'b0;
    chk_val("t5_idle_next", idle, 1);
    chk_val("t5_write_low", write, 0);
    force_busy = 1'b0;
    tick(12);
    chk_val("t5_no_more", log_q.size(), 2);
    chk_val("t5_still_idle", idle, 1);
    drive_req(1'b0, 8'h50, 8'h09, acc);
    wait_idle("t5_after", 200);
    chk_val("t5_after_n", log_q.size(), 4);
    chk_val("t5_cache_miss", log_at(2), {2'd0, 8'h50});
    chk_val("t5_after_data", log_at(3), {2'd1, 8'h09});
    chk_val("t5_err_sticky", err_timeout, 1);

    // 6: async reset in the middle of an address strobe
    clear_log();
    drive_req(1'b1, 8'h60, 8'h77, acc);
    tick(1);
    chk_val("t6_strobe_up", write, 1);
    chk_val("t6_strobe_addr", addr, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_val("t6_write_async", write, 0);
    chk_val("t6_addr_rst", addr, 0);
    chk_val("t6_din_rst", din, 0);
    chk_val("t6_err_rst", err_timeout, 0);
    chk_val("t6_idle_rst", idle, 1);
    chk_val("t6_ready_rst", req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    clear_log();
    drive_req(1'b1, 8'h60, 8'h78, acc);
    wait_idle("t6_after", 200);
    chk_val("t6_after_n", log_q.size(), 2);
    chk_val("t6_after_addr", log_at(0), {2'd2, 8'h60});
    chk_val("t6_after_data", log_at(1), {2'd3, 8'h78});

    chk_val("no_b2b_write", b2b_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
